rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters; a grant is held until released.
- Uses rotating-priority selection built on the same 8-to-3 priority-encoding scheme as the encoder blocks.
- Outputs a one-hot grant and a 3-bit encoded owner index for downstream muxing.
- Sits between requesting units and a single shared datapath (bus, memory port, encoder-fed mux).

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles before a forced release. Legal range 2..255.
- CNT_W, $clog2(MAX_HOLD+1): hold-counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable. Gates new grants only.
- req  input  8  request vector; bit i = requester i.
- done  input  1  release strobe from the current owner. Sampled only in GRANT.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  encoded owner index, registered. Valid when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant was forcibly released.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0. Takes effect immediately, including mid-grant.
- State IDLE:
  - If en=1 and |req, pick the first set bit of req scanning ptr, ptr+1, ... ptr+7 (mod 8).
  - Register gnt/gnt_idx, set hold_cnt=1, move to GRANT.
  - Grant appears one cycle after the req sample. Latency 1.
  - If en=0 or req=0, stay in IDLE with outputs 0.
- State GRANT: the owner is gnt_idx. Release conditions, in priority order:
  - done=1: normal release.
  - req[owner]=0: normal release.
  - hold_cnt==MAX_HOLD: forced release.
- On release:
  - Next cycle: gnt=0, gnt_valid=0, state=IDLE, ptr=owner+1 (wraps 7 -> 0).
  - Forced release only: timeout=1 for exactly that one cycle.
  - If done and the counter limit coincide, done wins and timeout stays 0.
- While holding, hold_cnt increments each cycle. It cannot exceed MAX_HOLD.
- Mandatory single gap cycle (IDLE) between any two grants, including a re-grant to the same requester.
- en=0 during GRANT does not abort the grant. Only new grants are blocked.
- Non-owner req changes during GRANT are ignored until the next IDLE cycle.
- req must be synchronous to clk. No internal synchronizers.
- gnt is always one-hot or zero; gnt_idx is consistent with gnt whenever gnt_valid=1.

Decomposition:
- Package rr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - constant N_REQ=8, IDX_W=3.
- Sub-module rr_pick8, purely combinational:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: hit, idx[2:0].
  - Operation: rotate req right by ptr, 8-to-3 priority encode (lowest index first, two 4-to-2 halves), add ptr mod 8.
- Top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
- After reset, req=8'b1000_0001, en=1 -> gnt=8'h01, gnt_idx=0 at next edge. Pulse done -> gap cycle with gnt=0. Next grant gnt=8'h80, gnt_idx=7 (ptr=1 skips bit 0).
- req=8'hFF held, done pulsed on each grant's 2nd cycle -> gnt_idx sequence 0,1,2,...,7,0. Each grant lasts 2 cycles followed by 1 gap cycle.
- req=8'h08 only, done never asserted, MAX_HOLD=16 -> gnt=8'h08 for exactly 16 cycles, then gap cycle with timeout=1 and gnt=0, then re-grant idx 3 with timeout back to 0.
- Owner 5 drops req[5] on its 3rd grant cycle -> next cycle gnt=0 and timeout=0. Next grant goes to the lowest requester from idx 6 upward (e.g. req=8'h05 -> idx 0).
- en=0 with req=8'hFF -> no grant for 10 cycles. Deassert en mid-grant of idx 2 -> grant continues until done; no new grant follows while en=0.
- Assert rst_n=0 between clock edges during the grant of idx 6 -> gnt, gnt_valid and gnt_idx go to 0 immediately. After release, the first grant with req=8'hFF is idx 0 (ptr reset).

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Also holds the 4-to-2 priority encoder used to build the 8-to-3 picker.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Returns {hit, idx[1:0]}; the lowest set bit wins.
  function automatic logic [2:0] pe4(input logic [3:0] v);
    logic [2:0] res;
    res = 3'b000;
    if (v[0]) begin
      res = 3'b100;
    end else if (v[1]) begin
      res = 3'b101;
    end else if (v[2]) begin
      res = 3'b110;
    end else if (v[3]) begin
      res = 3'b111;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod 8.
// Purely combinational; the result index is absolute, not relative to ptr.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [2:0]         lo_res;
  logic [2:0]         hi_res;
  logic [IDX_W-1:0]   enc;

  always_comb begin
    // Doubling the vector turns the rotate-right into a plain shift.
    dbl    = {req, req} >> ptr;
    rot    = dbl[N_REQ-1:0];
    lo_res = pe4(rot[3:0]);
    hi_res = pe4(rot[7:4]);
    hit    = lo_res[2] | hi_res[2];
    enc    = lo_res[2] ? {1'b0, lo_res[1:0]} : {1'b1, hi_res[1:0]};
    idx    = enc + ptr;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; a grant is held until done, request drop,
// or the hold limit, and every grant is followed by at least one idle cycle.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             at_limit;
  logic             release_now;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    owner_req   = req[gnt_idx];
    at_limit    = (hold_cnt == CNT_W'(MAX_HOLD));
    release_now = done || !owner_req || at_limit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (en && pick_hit) begin
            gnt       <= N_REQ'(1) << pick_idx;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= CNT_W'(1);
            state     <= StGrant;
          end
        end
        StGrant: begin
          if (release_now) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= gnt_idx + IDX_W'(1);
            state     <= StIdle;
            // Only a limit hit with no normal release reason counts as forced.
            timeout   <= !done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid_or : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt);
  a_idx_match : assert property (@(posedge clk) disable iff (!rst_n)
                                  gnt_valid |-> gnt == (N_REQ'(1) << gnt_idx));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with hand-computed grant sequences.
module tb_rr_arbiter8;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec;
  int n_err;

  rr_arbiter8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    check({tag, ".gnt"}, 32'(gnt), 32'(8'h01 << idx));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
    check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    check_idle("reset", 1'b0);
    check("reset.idx", 32'(gnt_idx), 32'd0);
    rst_n = 1'b1;

    // Basic grant, release, and pointer skip past the previous owner.
    req = 8'h81;
    en  = 1'b1;
    tick();
    check_grant("first", 3'd0);
    done = 1'b1;
    tick();
    check_idle("first_gap", 1'b0);
    done = 1'b0;
    tick();
    check_grant("second", 3'd7);
    done = 1'b1;
    tick();
    check_idle("second_gap", 1'b0);
    done = 1'b0;

    // Full rotation with all requesting: 2 grant cycles and 1 gap each.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_grant("rot_c1", 3'(k % 8));
      tick();
      check_grant("rot_c2", 3'(k % 8));
      done = 1'b1;
      tick();
      check_idle("rot_gap", 1'b0);
      done = 1'b0;
    end

    // Single requester held to the limit: 16 grant cycles, then forced release.
    req = 8'h08;
    for (int c = 0; c < 16; c++) begin
      tick();
      check_grant("hold", 3'd3);
    end
    tick();
    check_idle("forced_gap", 1'b1);
    tick();
    check_grant("regrant", 3'd3);
    check("regrant.timeout", 32'(timeout), 32'd0);
    // Done on the limit cycle: normal release, no timeout.
    for (int c = 0; c < 15; c++) tick();
    check_grant("hold16", 3'd3);
    done = 1'b1;
    tick();
    check_idle("done_at_limit", 1'b0);
    done = 1'b0;

    // Owner 5 drops its request on the 3rd grant cycle.
    req = 8'h20;
    tick();
    check_grant("own5_c1", 3'd5);
    tick();
    tick();
    check_grant("own5_c3", 3'd5);
    req = 8'h05;
    tick();
    check_idle("drop_gap", 1'b0);
    tick();
    check_grant("after_drop", 3'd0);
    done = 1'b1;
    tick();
    check_idle("after_drop_gap", 1'b0);
    done = 1'b0;

    // en=0 blocks new grants.
    en  = 1'b0;
    req = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("en_off.gnt", 32'(gnt), 32'd0);
    end
    // en dropped mid-grant does not abort the grant.
    en  = 1'b1;
    req = 8'h04;
    tick();
    check_grant("en_grant", 3'd2);
    en  = 1'b0;
    req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_grant("en_hold", 3'd2);
    end
    done = 1'b1;
    tick();
    check_idle("en_release", 1'b0);
    done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en_blocked.gnt", 32'(gnt), 32'd0);
    end

    // Asynchronous reset between edges during the grant of idx 6.
    en  = 1'b1;
    req = 8'h40;
    tick();
    check_grant("pre_rst", 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst", 1'b0);
    check("async_rst.idx", 32'(gnt_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    req   = 8'hFF;
    tick();
    check_grant("post_rst", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
